// File: rtl/wifire_pkg.sv
// Shared definitions for the wifire 802.15.4 PHY blocks: FSM states, frame
// constants and the nibble-wide reflected CRC-16 step.
package wifire_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    PHR      = 3'd3,
    PSDU     = 3'd4,
    FCS      = 3'd5
  } wifire_state_e;

  localparam logic [7:0]  WIFIRE_SFD           = 8'hA7;
  localparam logic [7:0]  WIFIRE_PREAMBLE_SYMS = 8'd8;
  localparam logic [15:0] WIFIRE_CRC_POLY      = 16'h8408;
  localparam logic [6:0]  WIFIRE_MAX_LEN       = 7'd127;

  // Data bits enter LSB first, matching the low-nibble-first symbol order.
  function automatic logic [15:0] crc16_nibble(input logic [15:0] crc,
                                               input logic [3:0]  nib);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) begin
        c = {1'b0, c[15:1]} ^ WIFIRE_CRC_POLY;
      end else begin
        c = {1'b0, c[15:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/wifire_crc16_nibble.sv
// ITU-T CRC-16 (reflected, init 0) register advanced one nibble per enable;
// shared by the frame encoder and the decoder's FCS checker.
module wifire_crc16_nibble
  import wifire_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [3:0]  nibble,
  output logic [15:0] crc
);

  logic [15:0] crc_r;

  // CRC state register; clear has priority over a same-cycle update
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_r <= 16'h0000;
    end else if (clear) begin
      crc_r <= 16'h0000;
    end else if (enable) begin
      crc_r <= crc16_nibble(crc_r, nibble);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/wifire_frame_encoder.sv
// 802.15.4 PPDU transmitter: buffers one MPDU and streams preamble, SFD, PHR,
// payload and FCS as 4-bit symbols over a stb/rdy handshake.
module wifire_frame_encoder
  import wifire_pkg::*;
#(
  parameter logic [7:0] SFD_BYTE      = WIFIRE_SFD,
  parameter logic [7:0] PREAMBLE_SYMS = WIFIRE_PREAMBLE_SYMS
) (
  input  logic       dsp_clk,
  input  logic       reset,
  input  logic       buf_we_i,
  input  logic [6:0] buf_addr_i,
  input  logic [7:0] buf_dat_i,
  input  logic [6:0] len_i,
  input  logic       start_i,
  output logic [3:0] tx_sym_o,
  output logic       tx_sym_stb_o,
  input  logic       tx_sym_rdy_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  wifire_state_e state_r, state_s;
  logic [7:0]  sym_cnt_r, sym_cnt_s;
  logic        nib_r, nib_s;
  logic [6:0]  byte_idx_r, byte_idx_s;
  logic [6:0]  len_r, len_s;
  logic [3:0]  sym_r, sym_s;
  logic [3:0]  hi_nib_r, hi_nib_s;
  logic        stb_r, stb_s, busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic [7:0]  mem_r [0:127];
  logic [7:0]  rd_q_r;
  logic [6:0]  rd_addr_s;
  logic        xfer_s, start_ok_s, crc_en_s;
  logic [15:0] crc_s, crc_fcs_s;
  logic [7:0]  phr_s;

  assign xfer_s     = stb_r & tx_sym_rdy_i;
  assign start_ok_s = (state_r == IDLE) && start_i && (len_i >= 7'd2);
  assign crc_en_s   = xfer_s && (state_r == PSDU);
  assign phr_s      = {1'b0, len_r};
  // Leaving PSDU, the last payload nibble is folded in on the same edge.
  assign crc_fcs_s  = (state_r == PSDU) ? crc16_nibble(crc_s, sym_r) : crc_s;
  assign rd_addr_s  = (state_r == PSDU) ? (byte_idx_r + 7'd1) : 7'd0;

  wifire_crc16_nibble u_crc (
    .clk    (dsp_clk),
    .reset  (reset),
    .clear  (start_ok_s),
    .enable (crc_en_s),
    .nibble (sym_r),
    .crc    (crc_s)
  );

  // Next-symbol selection: advances only on start or on an accepted symbol
  always_comb begin
    state_s    = state_r;
    sym_cnt_s  = sym_cnt_r;
    nib_s      = nib_r;
    byte_idx_s = byte_idx_r;
    len_s      = len_r;
    sym_s      = sym_r;
    hi_nib_s   = hi_nib_r;
    stb_s      = stb_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s   = PREAMBLE;
          sym_cnt_s = 8'd0;
          len_s     = len_i;
          sym_s     = 4'h0;
          stb_s     = 1'b1;
          busy_s    = 1'b1;
        end else begin
          err_s  = start_i;
          stb_s  = 1'b0;
          busy_s = 1'b0;
        end
      end
      PREAMBLE: begin
        if (xfer_s && (sym_cnt_r == PREAMBLE_SYMS - 8'd1)) begin
          state_s   = SFD;
          sym_cnt_s = 8'd0;
          sym_s     = SFD_BYTE[3:0];
        end else if (xfer_s) begin
          sym_cnt_s = sym_cnt_r + 8'd1;
          sym_s     = 4'h0;
        end else begin
          sym_s = sym_r;
        end
      end
      SFD: begin
        if (xfer_s && (sym_cnt_r == 8'd0)) begin
          sym_cnt_s = 8'd1;
          sym_s     = SFD_BYTE[7:4];
        end else if (xfer_s) begin
          state_s   = PHR;
          sym_cnt_s = 8'd0;
          sym_s     = phr_s[3:0];
        end else begin
          sym_s = sym_r;
        end
      end
      PHR: begin
        if (xfer_s && (sym_cnt_r == 8'd0)) begin
          sym_cnt_s = 8'd1;
          sym_s     = phr_s[7:4];
        end else if (xfer_s && (len_r == 7'd2)) begin
          state_s   = FCS;
          sym_cnt_s = 8'd0;
          sym_s     = crc_fcs_s[3:0];
        end else if (xfer_s) begin
          state_s    = PSDU;
          byte_idx_s = 7'd0;
          nib_s      = 1'b0;
          sym_s      = rd_q_r[3:0];
          hi_nib_s   = rd_q_r[7:4];
        end else begin
          sym_s = sym_r;
        end
      end
      PSDU: begin
        if (xfer_s && !nib_r) begin
          nib_s = 1'b1;
          sym_s = hi_nib_r;
        end else if (xfer_s && (byte_idx_r == len_r - 7'd3)) begin
          state_s   = FCS;
          sym_cnt_s = 8'd0;
          sym_s     = crc_fcs_s[3:0];
        end else if (xfer_s) begin
          byte_idx_s = byte_idx_r + 7'd1;
          nib_s      = 1'b0;
          sym_s      = rd_q_r[3:0];
          hi_nib_s   = rd_q_r[7:4];
        end else begin
          sym_s = sym_r;
        end
      end
      FCS: begin
        if (xfer_s && (sym_cnt_r == 8'd3)) begin
          state_s   = IDLE;
          sym_cnt_s = 8'd0;
          sym_s     = 4'h0;
          stb_s     = 1'b0;
          busy_s    = 1'b0;
          done_s    = 1'b1;
        end else if (xfer_s) begin
          sym_cnt_s = sym_cnt_r + 8'd1;
          sym_s     = crc_fcs_s[{sym_cnt_s[1:0], 2'b00} +: 4];
        end else begin
          sym_s = sym_r;
        end
      end
      default: begin
        state_s = IDLE;
        stb_s   = 1'b0;
        busy_s  = 1'b0;
        sym_s   = 4'h0;
      end
    endcase
  end

  // FSM, counters and registered outputs
  always_ff @(posedge dsp_clk) begin
    if (reset) begin
      state_r    <= IDLE;
      sym_cnt_r  <= 8'd0;
      nib_r      <= 1'b0;
      byte_idx_r <= 7'd0;
      len_r      <= 7'd0;
      sym_r      <= 4'h0;
      hi_nib_r   <= 4'h0;
      stb_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      sym_cnt_r  <= sym_cnt_s;
      nib_r      <= nib_s;
      byte_idx_r <= byte_idx_s;
      len_r      <= len_s;
      sym_r      <= sym_s;
      hi_nib_r   <= hi_nib_s;
      stb_r      <= stb_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  // Frame buffer; the read port keeps the next payload byte ready at all times
  always_ff @(posedge dsp_clk) begin
    if (buf_we_i && (state_r == IDLE)) begin
      mem_r[buf_addr_i] <= buf_dat_i;
    end
    rd_q_r <= mem_r[rd_addr_s];
  end

  assign tx_sym_o     = sym_r;
  assign tx_sym_stb_o = stb_r;
  assign tx_busy_o    = busy_r;
  assign tx_done_o    = done_r;
  assign tx_err_o     = err_r;

endmodule

// File: tb/tb_wifire_frame_encoder.sv
// Directed bench for wifire_frame_encoder: symbol streams with hand-computed
// headers and FCS values, stalls, error/ignore cases and mid-frame reset.
module tb_wifire_frame_encoder;

  logic       dsp_clk = 1'b0;
  logic       reset;
  logic       buf_we_i;
  logic [6:0] buf_addr_i;
  logic [7:0] buf_dat_i;
  logic [6:0] len_i;
  logic       start_i;
  logic [3:0] tx_sym_o;
  logic       tx_sym_stb_o;
  logic       tx_sym_rdy_i;
  logic       tx_busy_o;
  logic       tx_done_o;
  logic       tx_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tb_mem [0:127];
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int done_cnt, stall_bad, extra_stb, done_gap, diff;
  bit timed_out;

  wifire_frame_encoder dut (
    .dsp_clk      (dsp_clk),
    .reset        (reset),
    .buf_we_i     (buf_we_i),
    .buf_addr_i   (buf_addr_i),
    .buf_dat_i    (buf_dat_i),
    .len_i        (len_i),
    .start_i      (start_i),
    .tx_sym_o     (tx_sym_o),
    .tx_sym_stb_o (tx_sym_stb_o),
    .tx_sym_rdy_i (tx_sym_rdy_i),
    .tx_busy_o    (tx_busy_o),
    .tx_done_o    (tx_done_o),
    .tx_err_o     (tx_err_o)
  );

  always #5 dsp_clk = ~dsp_clk;

  task automatic tick();
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic write_byte(input logic [6:0] addr, input logic [7:0] dat);
    buf_we_i = 1'b1; buf_addr_i = addr; buf_dat_i = dat;
    tick();
    buf_we_i = 1'b0;
    tb_mem[addr] = dat;
  endtask

  task automatic start_frame(input logic [6:0] len);
    len_i = len; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Expected PPDU nibbles built from the frame format and a given FCS value
  task automatic build_exp(input logic [6:0] len, input logic [15:0] fcs);
    logic [7:0] phr;
    phr = {1'b0, len};
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(4'h0);
    exp_q.push_back(4'h7); exp_q.push_back(4'hA);
    exp_q.push_back(phr[3:0]); exp_q.push_back(phr[7:4]);
    for (int i = 0; i < int'(len) - 2; i++) begin
      exp_q.push_back(tb_mem[i][3:0]); exp_q.push_back(tb_mem[i][7:4]);
    end
    exp_q.push_back(fcs[3:0]);  exp_q.push_back(fcs[7:4]);
    exp_q.push_back(fcs[11:8]); exp_q.push_back(fcs[15:12]);
  endtask

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Collects transferred symbols until done; poke 1 = start during frame, 2 = write addr 0
  task automatic run_capture(input bit rand_rdy, input int poke_at, input int poke_kind);
    logic [3:0] held_sym;
    bit held, done_seen;
    int post, last_xfer;
    got_q.delete();
    done_cnt = 0; stall_bad = 0; extra_stb = 0; done_gap = -1; timed_out = 1'b1;
    held = 1'b0; held_sym = 4'h0; done_seen = 1'b0; post = 0; last_xfer = -100;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (held && (tx_sym_stb_o !== 1'b1 || tx_sym_o !== held_sym)) stall_bad++;
      if (tx_done_o === 1'b1) begin
        done_cnt++;
        if (!done_seen) done_gap = cyc - last_xfer;
        done_seen = 1'b1;
      end
      if (done_seen) begin
        if (tx_sym_stb_o !== 1'b0 || tx_busy_o !== 1'b0) extra_stb++;
        post++;
        if (post == 3) begin
          timed_out = 1'b0;
          break;
        end
      end
      tx_sym_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i = 1'b0; buf_we_i = 1'b0;
      if (cyc == poke_at && poke_kind == 1) begin
        start_i = 1'b1; len_i = 7'd5;
      end else if (cyc == poke_at && poke_kind == 2) begin
        buf_we_i = 1'b1; buf_addr_i = 7'd0; buf_dat_i = 8'hFF;
      end
      if (tx_sym_stb_o === 1'b1 && tx_sym_rdy_i) begin
        got_q.push_back(tx_sym_o);
        last_xfer = cyc;
      end
      held = (tx_sym_stb_o === 1'b1) && !tx_sym_rdy_i;
      held_sym = tx_sym_o;
      tick();
    end
    tx_sym_rdy_i = 1'b1; start_i = 1'b0; buf_we_i = 1'b0;
  endtask

  task automatic check_frame(input string name);
    diff = first_diff();
    n_checks++;
    if (diff != -1) begin
      n_fail++;
      $display("FAIL %s stream: first bad index %0d got %0d syms expected %0d syms", name, diff, got_q.size(), exp_q.size());
    end
    n_checks++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL %s timeout: got no done within budget, expected done", name);
    end
    n_checks++;
    if (done_cnt != 1 || done_gap != 1) begin
      n_fail++;
      $display("FAIL %s done: got %0d pulses gap %0d, expected 1 pulse gap 1", name, done_cnt, done_gap);
    end
    n_checks++;
    if (stall_bad != 0 || extra_stb != 0) begin
      n_fail++;
      $display("FAIL %s stability: got %0d stall changes %0d post-done stb/busy, expected 0 0", name, stall_bad, extra_stb);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; buf_we_i = 1'b0; buf_addr_i = 7'd0; buf_dat_i = 8'h00;
    len_i = 7'd0; start_i = 1'b0; tx_sym_rdy_i = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({tx_sym_o, tx_sym_stb_o, tx_busy_o, tx_done_o, tx_err_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 00", {tx_sym_o, tx_sym_stb_o, tx_busy_o, tx_done_o, tx_err_o});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 9; i++) write_byte(7'(i), 8'h31 + 8'(i));
    build_exp(7'd11, 16'h2189);
    start_frame(7'd11);
    n_checks++;
    if (tx_busy_o !== 1'b1 || tx_sym_stb_o !== 1'b1 || tx_sym_o !== 4'h0) begin
      n_fail++;
      $display("FAIL first_symbol: got busy %b stb %b sym %h expected 1 1 0", tx_busy_o, tx_sym_stb_o, tx_sym_o);
    end
    run_capture(1'b0, -1, 0);
    check_frame("basic");
  endtask

  task automatic test_stall();
    build_exp(7'd11, 16'h2189);
    start_frame(7'd11);
    run_capture(1'b1, -1, 0);
    check_frame("stall");
  endtask

  task automatic test_len2();
    build_exp(7'd2, 16'h0000);
    start_frame(7'd2);
    run_capture(1'b0, -1, 0);
    check_frame("len2");
  endtask

  task automatic test_err();
    start_frame(7'd1);
    n_checks++;
    if (tx_err_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_sym_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_err: got err %b busy %b stb %b expected 1 0 0", tx_err_o, tx_busy_o, tx_sym_stb_o);
    end
    tick();
    n_checks++;
    if (tx_err_o !== 1'b0 || tx_busy_o !== 1'b0 || tx_sym_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_after: got err %b busy %b stb %b expected 0 0 0", tx_err_o, tx_busy_o, tx_sym_stb_o);
    end
  endtask

  task automatic test_start_busy();
    build_exp(7'd11, 16'h2189);
    start_frame(7'd11);
    run_capture(1'b0, 20, 1);
    check_frame("start_busy");
  endtask

  task automatic test_write_busy();
    build_exp(7'd11, 16'h2189);
    start_frame(7'd11);
    run_capture(1'b0, 5, 2);
    check_frame("write_busy");
    start_frame(7'd11);
    run_capture(1'b0, -1, 0);
    check_frame("retransmit");
  endtask

  task automatic test_reset_mid();
    int bad;
    build_exp(7'd11, 16'h2189);
    start_frame(7'd11);
    repeat (14) tick();
    n_checks++;
    if (tx_sym_o !== exp_q[14] || tx_sym_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_psdu_sym: got %h stb %b expected %h 1", tx_sym_o, tx_sym_stb_o, exp_q[14]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({tx_sym_o, tx_sym_stb_o, tx_busy_o, tx_done_o, tx_err_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 00", {tx_sym_o, tx_sym_stb_o, tx_busy_o, tx_done_o, tx_err_o});
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx_done_o !== 1'b0 || tx_sym_stb_o !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got %0d active cycles expected 0", bad);
    end
    start_frame(7'd11);
    run_capture(1'b0, -1, 0);
    check_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len2();
    test_err();
    test_start_busy();
    test_write_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
